// File: rtl/tdc_meas_sequencer_if.sv
// Signal bundle between the measurement sequencer and its host, TDC datapath and
// downstream consumer; the sequencer is the master side.
interface tdc_meas_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             meas_req;
    logic             tdc_int;
    logic             rd_done;
    logic             res_done;
    logic [63:0]      res_data;
    logic             out_ready;
    logic             tdc_init;
    logic             start_o;
    logic             stop_o;
    logic             rd_req;
    logic             out_valid;
    logic [63:0]      out_data;
    logic             busy;
    logic             timeout_err;
    logic [2:0]       err_state;
    logic [CNT_W-1:0] meas_cnt;

    modport master (
        input  meas_req, tdc_int, rd_done, res_done, res_data, out_ready,
        output tdc_init, start_o, stop_o, rd_req, out_valid, out_data,
               busy, timeout_err, err_state, meas_cnt
    );

    modport slave (
        output meas_req, tdc_int, rd_done, res_done, res_data, out_ready,
        input  tdc_init, start_o, stop_o, rd_req, out_valid, out_data,
               busy, timeout_err, err_state, meas_cnt
    );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// Sequences one time-of-flight measurement: TDC init, start/stop phases with register
// reads, result capture and downstream handoff, guarded by a per-state watchdog.
module tdc_meas_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned INIT_CYC    = 16,
    parameter int          CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    tdc_meas_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        ST_WAIT = 3'd2,
        ST_RD   = 3'd3,
        SP_WAIT = 3'd4,
        SP_RD   = 3'd5,
        RESULT  = 3'd6,
        OUTPUT  = 3'd7
    } state_t;

    localparam logic [31:0] INIT_LAST = 32'(INIT_CYC - 1);
    localparam logic [31:0] WD_LAST   = 32'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      cyc_cnt;
    logic [63:0]      out_data_q;
    logic [2:0]       err_state_q;
    logic [CNT_W-1:0] meas_cnt_q;
    logic             waiting;
    logic             event_hit;
    logic             wd_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cyc_cnt <= '0;
        end else begin
            state <= state_nxt;
            // One counter serves both the INIT pulse width and the watchdog.
            if (state_nxt != state) begin
                cyc_cnt <= '0;
            end else if (state != IDLE && state != OUTPUT) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        waiting   = 1'b0;
        event_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.meas_req) state_nxt = INIT;
            end
            INIT: begin
                if (cyc_cnt == INIT_LAST) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                waiting   = 1'b1;
                event_hit = bus.tdc_int;
                if (event_hit) state_nxt = ST_RD;
            end
            ST_RD: begin
                waiting   = 1'b1;
                event_hit = bus.rd_done;
                if (event_hit) state_nxt = SP_WAIT;
            end
            SP_WAIT: begin
                waiting   = 1'b1;
                event_hit = bus.tdc_int;
                if (event_hit) state_nxt = SP_RD;
            end
            SP_RD: begin
                waiting   = 1'b1;
                event_hit = bus.rd_done;
                if (event_hit) state_nxt = RESULT;
            end
            RESULT: begin
                waiting   = 1'b1;
                event_hit = bus.res_done;
                if (event_hit) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
        endcase
        // A qualifying event in the expiry cycle takes priority over the abort.
        wd_expire = waiting && !event_hit && (cyc_cnt == WD_LAST);
        if (wd_expire) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            err_state_q <= '0;
            meas_cnt_q  <= '0;
        end else begin
            if (state == RESULT && bus.res_done) begin
                out_data_q <= bus.res_data;
            end
            if (state == IDLE && bus.meas_req) begin
                err_state_q <= 3'd0;
            end else if (wd_expire) begin
                err_state_q <= state;
            end
            if (state == OUTPUT && bus.out_ready) begin
                meas_cnt_q <= meas_cnt_q + 1'b1;
            end
        end
    end

    assign bus.tdc_init    = (state == INIT);
    assign bus.start_o     = (state == ST_WAIT) || (state == ST_RD);
    assign bus.stop_o      = (state == SP_WAIT) || (state == SP_RD);
    assign bus.rd_req      = ((state == ST_RD) || (state == SP_RD)) && (cyc_cnt == 32'd0);
    assign bus.out_valid   = (state == OUTPUT);
    assign bus.out_data    = out_data_q;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = wd_expire;
    assign bus.err_state   = err_state_q;
    assign bus.meas_cnt    = meas_cnt_q;
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed bench for tdc_meas_sequencer: nominal run, backpressure, watchdog aborts,
// event/expiry race, mid-run reset, spurious inputs and counter wrap.
module tb_tdc_meas_sequencer;
    localparam int CNT_W = 2;
    localparam logic [63:0] JUNK = 64'hFFFF_0000_FFFF_0000;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    int nInit, nRd, nStart, nStop, nValid, nTo;
    int firstInit, firstStop, firstValid, toAt, rdAt0, rdAt1;
    int unstable, cntMoved, busyAfterTo;

    always #5 clk = ~clk;

    tdc_meas_sequencer_if #(.CNT_W(CNT_W)) bus ();

    tdc_meas_sequencer #(
        .TIMEOUT_CYC(100),
        .INIT_CYC   (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of input drive; outputs are settled when this returns.
    task automatic applyStimulus(input logic req, input logic tint, input logic rdd,
                                 input logic resd, input logic [63:0] data, input logic ordy);
        @(posedge clk);
        #1;
        bus.meas_req  = req;
        bus.tdc_int   = tint;
        bus.rd_done   = rdd;
        bus.res_done  = resd;
        bus.res_data  = data;
        bus.out_ready = ordy;
        #2;
    endtask

    // Cycle i=0 carries the request; negative offsets mean the event never occurs.
    task automatic runSeq(input int nCyc, input int dSt, input int dRd1, input int dSp,
                          input int dRd2, input int dRes, input int dRdy, input int dSpur,
                          input logic [63:0] data, input logic [CNT_W-1:0] cntBefore);
        nInit = 0; nRd = 0; nStart = 0; nStop = 0; nValid = 0; nTo = 0;
        firstInit = -1; firstStop = -1; firstValid = -1; toAt = -1; rdAt0 = -1; rdAt1 = -1;
        unstable = 0; cntMoved = 0; busyAfterTo = -1;
        for (int i = 0; i < nCyc; i++) begin
            applyStimulus((i == 0) || (i == dSpur),
                          (i == dSt) || (i == dSp) || (dSpur >= 0 && i == dSpur + 5),
                          (i == dRd1) || (i == dRd2) || (i == dSpur),
                          (i == dRes),
                          (i == dRes) ? data : JUNK,
                          (i >= dRdy));
            if (bus.tdc_init) begin nInit++; if (firstInit < 0) firstInit = i; end
            if (bus.rd_req) begin
                if (nRd == 0) rdAt0 = i; else rdAt1 = i;
                nRd++;
            end
            if (bus.start_o) nStart++;
            if (bus.stop_o) begin nStop++; if (firstStop < 0) firstStop = i; end
            if (bus.out_valid) begin
                nValid++;
                if (firstValid < 0) firstValid = i;
                if (bus.out_data !== data) unstable++;
                if (bus.meas_cnt !== cntBefore) cntMoved++;
            end
            if (toAt >= 0 && toAt == i - 1) busyAfterTo = int'(bus.busy);
            if (bus.timeout_err) begin nTo++; toAt = i; end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.meas_req = 1'b0; bus.tdc_int = 1'b0; bus.rd_done = 1'b0;
        bus.res_done = 1'b0; bus.res_data = '0;  bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_tdc_init", bus.tdc_init, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_meas_cnt", bus.meas_cnt, 0);
        checkOutput("reset_err_state", bus.err_state, 0);
        reset_n = 1'b1;

        $display("[TB] nominal measurement");
        runSeq(45, 10, 15, 30, 35, 40, 0, -1, 64'd1_000_040, 2'd0);
        checkOutput("nom_init_cycles", nInit, 4);
        checkOutput("nom_init_first", firstInit, 1);
        checkOutput("nom_rd_pulses", nRd, 2);
        checkOutput("nom_rd_first", rdAt0, 11);
        checkOutput("nom_rd_second", rdAt1, 31);
        checkOutput("nom_start_cycles", nStart, 11);
        checkOutput("nom_stop_first", firstStop, 16);
        checkOutput("nom_stop_cycles", nStop, 20);
        checkOutput("nom_valid_first", firstValid, 41);
        checkOutput("nom_valid_cycles", nValid, 1);
        checkOutput("nom_out_data", bus.out_data, 64'd1_000_040);
        checkOutput("nom_meas_cnt", bus.meas_cnt, 1);
        checkOutput("nom_busy_end", bus.busy, 0);
        checkOutput("nom_no_timeout", nTo, 0);

        $display("[TB] backpressure");
        runSeq(95, 10, 15, 30, 35, 40, 91, -1, 64'h0123_4567_89AB_CDEF, 2'd1);
        checkOutput("bp_valid_cycles", nValid, 51);
        checkOutput("bp_data_stable", unstable, 0);
        checkOutput("bp_cnt_held", cntMoved, 0);
        checkOutput("bp_meas_cnt", bus.meas_cnt, 2);
        checkOutput("bp_busy_end", bus.busy, 0);

        $display("[TB] stop-phase timeout");
        runSeq(120, 10, 15, -1, -1, -1, 0, -1, 64'd0, 2'd2);
        checkOutput("to_stop_first", firstStop, 16);
        checkOutput("to_pulse_at", toAt, 115);
        checkOutput("to_pulse_count", nTo, 1);
        checkOutput("to_stop_cycles", nStop, 100);
        checkOutput("to_busy_after", busyAfterTo, 0);
        checkOutput("to_err_state", bus.err_state, 4);
        checkOutput("to_meas_cnt", bus.meas_cnt, 2);

        $display("[TB] result lost in stop read");
        runSeq(140, 10, 15, 30, 35, 33, 0, -1, 64'd777, 2'd2);
        checkOutput("lost_pulse_at", toAt, 135);
        checkOutput("lost_err_state", bus.err_state, 6);
        checkOutput("lost_no_valid", nValid, 0);

        $display("[TB] rd_done on watchdog expiry");
        runSeq(140, 10, 110, 120, 125, 130, 0, -1, 64'd42, 2'd2);
        checkOutput("race_no_timeout", nTo, 0);
        checkOutput("race_stop_first", firstStop, 111);
        checkOutput("race_start_cycles", nStart, 106);
        checkOutput("race_valid_first", firstValid, 131);
        checkOutput("race_out_data", bus.out_data, 64'd42);
        checkOutput("race_err_cleared", bus.err_state, 0);
        checkOutput("race_meas_cnt", bus.meas_cnt, 3);

        $display("[TB] reset during stop read");
        runSeq(33, 10, 15, 30, 35, 40, 0, -1, 64'd5, 2'd3);
        checkOutput("rst_pre_stop", bus.stop_o, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_stop", bus.stop_o, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_meas_cnt", bus.meas_cnt, 0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        runSeq(45, 10, 15, 30, 35, 40, 0, -1, 64'd2_500, 2'd0);
        checkOutput("rst_run_valid_first", firstValid, 41);
        checkOutput("rst_run_rd_pulses", nRd, 2);
        checkOutput("rst_run_out_data", bus.out_data, 64'd2_500);
        checkOutput("rst_run_meas_cnt", bus.meas_cnt, 1);

        $display("[TB] spurious inputs and overlapping request");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, JUNK, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("spur_idle_busy", bus.busy, 0);
        checkOutput("spur_idle_rd_req", bus.rd_req, 0);
        runSeq(45, 10, 15, 30, 35, 40, 0, 7, 64'd3, 2'd1);
        checkOutput("ovl_rd_pulses", nRd, 2);
        checkOutput("ovl_rd_first", rdAt0, 11);
        checkOutput("ovl_stop_first", firstStop, 16);
        checkOutput("ovl_start_cycles", nStart, 11);
        checkOutput("ovl_valid_first", firstValid, 41);
        checkOutput("ovl_busy_end", bus.busy, 0);
        checkOutput("ovl_meas_cnt", bus.meas_cnt, 2);

        for (int k = 0; k < 3; k++) begin
            runSeq(45, 10, 15, 30, 35, 40, 0, -1, 64'd100 + 64'(k), 2'(k + 2));
            if (k == 1) checkOutput("wrap_to_zero", bus.meas_cnt, 0);
            if (k == 2) checkOutput("wrap_fifth", bus.meas_cnt, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
